// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
//   state_t : FSM state codes (IDLE=0, RUN=1, DONE=2; code 3 is illegal)
//   STATE_W : width of the state register
package serial_add_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Combinational 1-bit full adder cell. The sequencer time-shares this one cell.
//   a, b, c : addend bits and carry-in
//   s       : sum bit
//   cout    : carry-out
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer. One bit per clock, LSB first, through a
// single fa_bit cell with a registered carry. Start accepted at T gives done
// at T+WIDTH+1.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, only looked at in IDLE
//   sub        : 0 -> a+b+cin, 1 -> a-b (cin ignored)
//   a, b, cin  : operands, captured with the accepted start
//   busy       : high whenever not IDLE
//   done       : one-cycle pulse when sum/cout are valid
//   sum, cout  : result; held until overwritten by the next operation
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  op_a, op_b;
    logic              carry;
    logic              cell_s, cell_c;
    logic              last_bit;

    assign last_bit = (cnt == CNT_LAST);

    fa_bit u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .c    (carry),
        .s    (cell_s),
        .cout (cell_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;   // recover from the unused code
        endcase
    end

    // Datapath: operand shift registers, carry register, bit counter, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1: invert b once at capture and
                        // seed the carry with 1.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    sum   <= {cell_s, sum[WIDTH-1:1]};
                    carry <= cell_c;
                    // Wrap explicitly so cnt never passes WIDTH-1 for
                    // non-power-of-two widths.
                    if (last_bit) begin
                        cout <= cell_c;
                        cnt  <= '0;
                    end else begin
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, sub, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {cout, sum} from plain unsigned arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        int r;
        logic [W:0] res;
        if (s) begin
            r = (int'(x) - int'(y)) & 255;
            res = {(x >= y), 8'(r)};
        end else begin
            r = int'(x) + int'(y) + int'(c);
            res = 9'(r);
        end
        return res;
    endfunction

    // One operation with full timing checks; operands scrambled after acceptance.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tcin, input logic tsub);
        logic [W:0] e;
        int n;
        logic busy_ok;
        e = model(ta, tb_v, tcin, tsub);
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        n = 1;
        busy_ok = 1'b1;
        while (!done && n < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd9);
        chk("busy_run", 32'(busy_ok), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("sum", 32'(sum), 32'(e[W-1:0]));
        chk("cout", 32'(cout), 32'(e[W]));
        @(negedge clk);
        chk("done_pulse_len", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("sum_hold", 32'(sum), 32'(e[W-1:0]));
    endtask

    initial begin
        logic [W:0]   e1, e2, eq;
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        int           ndone, last_d;
        logic [W:0]   expq[$];

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        // Directed cases
        do_op(8'h5A, 8'h33, 1'b0, 1'b0);
        chk("t1_sum", 32'(sum), 32'h8D);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        chk("t2_cout", 32'(cout), 32'd1);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        do_op(8'h10, 8'h01, 1'b0, 1'b1);
        do_op(8'h01, 8'h02, 1'b1, 1'b1);
        chk("t3_borrow", 32'(cout), 32'd0);
        do_op(8'h00, 8'h00, 1'b0, 1'b1);
        do_op(8'h80, 8'h80, 1'b1, 1'b0);

        // Random operations
        for (int i = 0; i < 24; i++)
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        // Start held during busy with a=0: ignored until IDLE again
        e1 = model(8'hC3, 8'h29, 1'b1, 1'b0);
        e2 = model(8'h00, 8'h29, 1'b1, 1'b0);
        @(negedge clk);
        a = 8'hC3; b = 8'h29; cin = 1'b1; sub = 1'b0; start = 1'b1;
        ndone = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            a = 8'h00;
            if (n == 11) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    chk("hold_first_at", 32'(n), 32'd9);
                    chk("hold_first_sum", 32'(sum), 32'(e1[W-1:0]));
                    chk("hold_first_cout", 32'(cout), 32'(e1[W]));
                end else begin
                    chk("hold_second_at", 32'(n), 32'd19);
                    chk("hold_second_sum", 32'(sum), 32'(e2[W-1:0]));
                    chk("hold_second_cout", 32'(cout), 32'(e2[W]));
                end
            end
        end
        chk("hold_done_count", 32'(ndone), 32'd2);

        // Reset mid-run
        do_op(8'hF0, 8'h0E, 1'b1, 1'b0);
        @(negedge clk);
        a = 8'h77; b = 8'h11; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);            // T+1
        start = 1'b0;
        repeat (3) @(negedge clk); // T+4
        rst = 1'b1;
        @(negedge clk);            // T+5
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        ndone = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("mid_rst_no_done", 32'(ndone), 32'd0);

        // Back-to-back with start held; new operands loaded at each done
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        expq.push_back(model(ra, rb, rc, rs));
        @(negedge clk);
        a = ra; b = rb; cin = rc; sub = rs; start = 1'b1;
        ndone = 0;
        last_d = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (done) begin
                chk("b2b_spacing", 32'(n - last_d), (ndone == 0) ? 32'd9 : 32'd10);
                last_d = n;
                ndone++;
                eq = expq.pop_front();
                chk("b2b_sum", 32'(sum), 32'(eq[W-1:0]));
                chk("b2b_cout", 32'(cout), 32'(eq[W]));
                ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
                expq.push_back(model(ra, rb, rc, rs));
                a = ra; b = rb; cin = rc; sub = rs;
            end
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(ndone), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
